// File: rtl/sram_port_ctrl.sv
// Dual-port SRAM macro controller: write-only port 0, read-only port 1, with a
// 2-entry response FIFO, credit-style read backpressure and same-cycle write-first bypass.
module sram_port_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_resp_valid,
  input  logic                  rd_resp_ready,
  output logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic                  sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  logic                  rdy_q;
  logic                  inflight;
  logic                  byp;
  logic [DATA_WIDTH-1:0] byp_data;
  logic [DATA_WIDTH-1:0] fifo [2];
  logic                  rptr, wptr;
  logic [1:0]            count;
  logic [2:0]            occ;
  logic                  wa, ra, push, pop;
  logic [DATA_WIDTH-1:0] push_data;

  // Readies come up one edge after reset release so deassertion is clock-aligned.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;

  assign wr_ready      = rdy_q;
  assign wa            = wr_valid && wr_ready;
  assign rd_resp_valid = (count != 2'd0);
  assign rd_resp_data  = fifo[rptr];
  assign pop           = rd_resp_valid && rd_resp_ready;
  assign occ           = {1'b0, count} + {2'b00, inflight};
  // A same-cycle pop frees the slot the new read will need two edges later.
  assign rd_req_ready  = rdy_q && ((occ < 3'd2) || pop);
  assign ra            = rd_req_valid && rd_req_ready;
  assign push          = inflight;
  assign push_data     = byp ? byp_data : sram_dout1;

  assign sram_csb0   = !wa;
  assign sram_web0   = !wa;
  assign sram_wmask0 = 1'b1;
  assign sram_addr0  = wr_addr;
  assign sram_din0   = wr_data;
  assign sram_csb1   = !ra;
  assign sram_addr1  = rd_req_addr;

  // The macro returns old data on a same-cycle collision, so capture the write.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inflight <= 1'b0;
      byp      <= 1'b0;
      byp_data <= '0;
    end else begin
      inflight <= ra;
      byp      <= ra && wa && (wr_addr == rd_req_addr);
      byp_data <= wr_data;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= 2'd0;
      rptr  <= 1'b0;
      wptr  <= 1'b0;
    end else begin
      if (push) wptr <= !wptr;
      if (pop)  rptr <= !rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end

  always_ff @(posedge clk)
    if (push) fifo[wptr] <= push_data;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a behavioural SRAM macro and a
// queue scoreboard checked by an independent response monitor.
module tb_sram_port_ctrl;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk, rst_n;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic          rd_resp_valid, rd_resp_ready;
  logic [DW-1:0] rd_resp_data;
  logic          sram_csb0, sram_web0, sram_wmask0, sram_csb1;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0, sram_dout1;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] sram [0:(1<<AW)-1];

  sram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: registered read returns pre-write contents on a collision.
  initial begin
    for (int i = 0; i < (1<<AW); i++) sram[i] = '0;
    sram_dout1 = '0;
  end
  always @(posedge clk) begin
    if (!sram_csb1) sram_dout1 <= sram[sram_addr1];
    if (!sram_csb0 && !sram_web0 && sram_wmask0) sram[sram_addr0] <= sram_din0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_resp_valid && rd_resp_ready) begin
      if (sb.size() == 0) chk("unexpected_resp", {24'd0, rd_resp_data}, 32'hFFFF_FFFF);
      else chk("resp_data", {24'd0, rd_resp_data}, {24'd0, sb.pop_front()});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_of(input int a);
    logic [DW-1:0] v;
    v = 8'(a) ^ 8'h5A;
    if (a == 0) v = 8'h11;
    if (a == 3) v = 8'hA5;
    return v;
  endfunction

  task automatic wr(input int a, input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_addr = AW'(a); wr_data = d;
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input int a, input logic [DW-1:0] d);
    rd_req_valid = 1'b1; rd_req_addr = AW'(a);
    @(negedge clk);
    chk("rd_req_ready", {31'd0, rd_req_ready}, 32'd1);
    if (rd_req_ready) sb.push_back(d);
    cyc();
    rd_req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b1; wr_addr = 10'h005; wr_data = 8'h77;
    rd_req_valid = 1'b1; rd_req_addr = 10'h005; rd_resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_rd_req_ready", {31'd0, rd_req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, rd_resp_valid}, 32'd0);
    chk("rst_csb0_web0_csb1", {29'd0, sram_csb0, sram_web0, sram_csb1}, 32'h7);
    cyc();
    rst_n = 1'b1; wr_valid = 1'b0; rd_req_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("post_rst_readies", {30'd0, wr_ready, rd_req_ready}, 32'h3);
    cyc();

    for (int a = 0; a < 32; a++) wr(a, 8'(a) ^ 8'h5A);

    // Port-0 controls during a lone write.
    wr_valid = 1'b1; wr_addr = 10'h000; wr_data = 8'h11;
    @(negedge clk);
    chk("wr_ctrl", {29'd0, sram_csb0, sram_web0, sram_wmask0}, 32'h1);
    chk("wr_addr_din", {14'd0, sram_addr0, sram_din0}, {14'd0, 10'h000, 8'h11});
    chk("wr_csb1_idle", {31'd0, sram_csb1}, 32'd1);
    cyc();
    wr_valid = 1'b0;

    // Write then read next cycle; response latency check.
    wr(3, 8'hA5);
    rd(3, 8'hA5);
    @(negedge clk);
    chk("lat_inflight_cycle", {31'd0, rd_resp_valid}, 32'd0);
    cyc();
    @(negedge clk);
    chk("lat_resp_cycle", {31'd0, rd_resp_valid}, 32'd1);
    cyc();

    // Same-cycle collision must be write-first.
    wr_valid = 1'b1; wr_addr = 10'h3FF; wr_data = 8'h3C;
    rd(10'h3FF, 8'h3C);
    wr_valid = 1'b0;
    repeat (3) cyc();
    rd(10'h3FF, 8'h3C);
    wr(10'h020, 8'h77);
    rd(10'h020, 8'h77);
    repeat (4) cyc();

    // Backpressure: third read blocked until a pop.
    rd_resp_ready = 1'b0;
    rd(10'h010, exp_of(16));
    rd(10'h011, exp_of(17));
    rd_req_valid = 1'b1; rd_req_addr = 10'h012;
    @(negedge clk);
    chk("full_block_a", {31'd0, rd_req_ready}, 32'd0);
    cyc();
    @(negedge clk);
    chk("full_block_b", {31'd0, rd_req_ready}, 32'd0);
    cyc();
    rd_resp_ready = 1'b1;
    @(negedge clk);
    chk("pop_accept", {31'd0, rd_req_ready}, 32'd1);
    if (rd_req_ready) sb.push_back(exp_of(18));
    cyc();
    rd_req_valid = 1'b0;
    repeat (5) cyc();

    // Streaming reads: one accept and one response per cycle.
    for (int i = 0; i < 18; i++) begin
      rd_req_valid = (i < 16); rd_req_addr = AW'(i);
      @(negedge clk);
      if (i < 16) begin
        chk("stream_ready", {31'd0, rd_req_ready}, 32'd1);
        if (rd_req_ready) sb.push_back(exp_of(i));
      end
      if (i >= 2) chk("stream_valid", {31'd0, rd_resp_valid}, 32'd1);
      cyc();
    end
    rd_req_valid = 1'b0;
    repeat (3) cyc();

    // Reset with reads buffered and in flight: nothing may emerge afterwards.
    rd_resp_ready = 1'b0;
    rd(10'h010, exp_of(16));
    rd(10'h011, exp_of(17));
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, rd_resp_valid}, 32'd0);
    chk("midrst_readies", {30'd0, wr_ready, rd_req_ready}, 32'd0);
    sb.delete();
    repeat (2) cyc();
    rst_n = 1'b1; rd_resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("postrst_idle", {29'd0, rd_resp_valid, sram_csb0, sram_csb1}, 32'h3);
      cyc();
    end
    rd(3, 8'hA5);

    for (int i = 0; i < 50 && sb.size() != 0; i++) cyc();
    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
